// File: rtl/txt_cell_prefetch.sv
// Text-mode cell prefetcher: streams one line of cells from memory into a small FIFO feeding the pixel pipe.
// Define JX2_TXTPF_UNDERRUN_CNT_EN to add the saturating underrunCnt output.
module txt_cell_prefetch #(
    parameter int unsigned CELL_W     = 256,
    parameter int unsigned IX_W       = 14,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned LINE_CELLS = 80
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lineStart,
    input  logic [IX_W-1:0]   lineBase,
    output logic              reqValid,
    output logic [IX_W-1:0]   reqIx,
    input  logic              reqReady,
    input  logic              rspValid,
    input  logic [CELL_W-1:0] rspData,
    output logic              cellValid,
    output logic [CELL_W-1:0] cellData,
    input  logic              cellReady,
    output logic              lineDone,
    output logic              underrun
`ifdef JX2_TXTPF_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrunCnt
`endif
);

    localparam int unsigned      PW      = $clog2(DEPTH);
    localparam int unsigned      CW      = $clog2(DEPTH + 1);
    localparam logic [IX_W-1:0]  LAST    = IX_W'(LINE_CELLS);
    localparam logic [CW:0]      DEPTH_C = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IX_W-1:0]   base_q, base_d;
    logic [IX_W-1:0]   issued_q, issued_d;
    logic [IX_W-1:0]   popped_q, popped_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     discard_q, discard_d;
    logic              req_valid_q, req_valid_d;
    logic [IX_W-1:0]   req_ix_q, req_ix_d;
    logic              cell_valid_q, cell_valid_d;
    logic              line_done_q, line_done_d;
    logic              underrun_q, underrun_d;

    logic              hs, rsp_acc, drop, pop, fifo_we;
    logic [CELL_W-1:0] mem [DEPTH];

    // inflight covers every request not yet answered, including ones owed to an aborted line
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        issued_d     = issued_q;
        popped_d     = popped_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        fifo_cnt_d   = fifo_cnt_q;
        discard_d    = discard_q;
        line_done_d  = 1'b0;
        underrun_d   = 1'b0;
        fifo_we      = 1'b0;

        hs         = req_valid_q & reqReady;
        rsp_acc    = rspValid & (inflight_q != '0);
        drop       = rsp_acc & (discard_q != '0);
        pop        = cell_valid_q & cellReady;
        inflight_d = CW'(inflight_q + CW'(hs) - CW'(rsp_acc));
        if (drop) begin
            discard_d = discard_q - CW'(1);
        end

        if (lineStart) begin
            state_d    = S_FETCH;
            base_d     = lineBase;
            issued_d   = '0;
            popped_d   = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            fifo_cnt_d = '0;
            if (state_q != S_IDLE) begin
                discard_d = inflight_d;
            end
        end else begin
            if (hs) begin
                issued_d = issued_q + IX_W'(1);
            end
            if (rsp_acc && !drop) begin
                fifo_we = 1'b1;
                wptr_d  = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d   = rptr_q + PW'(1);
                popped_d = popped_q + IX_W'(1);
            end
            fifo_cnt_d = CW'(fifo_cnt_q + CW'(fifo_we) - CW'(pop));
            case (state_q)
                S_FETCH: begin
                    underrun_d = cellReady & ~cell_valid_q;
                    if (issued_d == LAST) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (popped_d == LAST) begin
                        state_d     = S_IDLE;
                        line_done_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        req_valid_d  = (state_d == S_FETCH) && (issued_d < LAST) &&
                       (((CW + 1)'(fifo_cnt_d) + (CW + 1)'(inflight_d)) < DEPTH_C);
        req_ix_d     = base_d + issued_d;
        cell_valid_d = (fifo_cnt_d != '0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            issued_q     <= '0;
            popped_q     <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            fifo_cnt_q   <= '0;
            inflight_q   <= '0;
            discard_q    <= '0;
            req_valid_q  <= 1'b0;
            req_ix_q     <= '0;
            cell_valid_q <= 1'b0;
            line_done_q  <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            issued_q     <= issued_d;
            popped_q     <= popped_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            inflight_q   <= inflight_d;
            discard_q    <= discard_d;
            req_valid_q  <= req_valid_d;
            req_ix_q     <= req_ix_d;
            cell_valid_q <= cell_valid_d;
            line_done_q  <= line_done_d;
            underrun_q   <= underrun_d;
        end
    end

    // FIFO storage needs no reset; validity is tracked by fifo_cnt_q
    always_ff @(posedge clock) begin
        if (fifo_we) begin
            mem[wptr_q] <= rspData;
        end
    end

    assign reqValid  = req_valid_q;
    assign reqIx     = req_ix_q;
    assign cellValid = cell_valid_q;
    assign cellData  = mem[rptr_q];
    assign lineDone  = line_done_q;
    assign underrun  = underrun_q;

`ifdef JX2_TXTPF_UNDERRUN_CNT_EN
    logic [15:0] ur_cnt_q, ur_cnt_d;

    always_comb begin
        ur_cnt_d = ur_cnt_q;
        if (underrun_d && (ur_cnt_q != 16'hFFFF)) begin
            ur_cnt_d = ur_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ur_cnt_q <= '0;
        end else begin
            ur_cnt_q <= ur_cnt_d;
        end
    end

    assign underrunCnt = ur_cnt_q;
`endif

endmodule

// File: tb/tb_txt_cell_prefetch.sv
// Directed bench for txt_cell_prefetch: memory model answering one cycle after each request,
// consumer recorder, and hand-computed expectations for line fetch, wrap, backpressure, abort, reset, underrun.
module tb_txt_cell_prefetch;

    localparam int unsigned CELL_W = 256;
    localparam int unsigned IX_W   = 14;

    logic              clock;
    logic              reset;
    logic              lineStart;
    logic [IX_W-1:0]   lineBase;
    logic              reqValid;
    logic [IX_W-1:0]   reqIx;
    logic              reqReady;
    logic              rspValid;
    logic [CELL_W-1:0] rspData;
    logic              cellValid;
    logic [CELL_W-1:0] cellData;
    logic              cellReady;
    logic              lineDone;
    logic              underrun;
`ifdef JX2_TXTPF_UNDERRUN_CNT_EN
    logic [15:0]       underrunCnt;
`endif

    txt_cell_prefetch dut (
        .clock     (clock),
        .reset     (reset),
        .lineStart (lineStart),
        .lineBase  (lineBase),
        .reqValid  (reqValid),
        .reqIx     (reqIx),
        .reqReady  (reqReady),
        .rspValid  (rspValid),
        .rspData   (rspData),
        .cellValid (cellValid),
        .cellData  (cellData),
        .cellReady (cellReady),
        .lineDone  (lineDone),
        .underrun  (underrun)
`ifdef JX2_TXTPF_UNDERRUN_CNT_EN
        ,
        .underrunCnt (underrunCnt)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;

    logic              rsp_en;
    int                rsp_serial;
    int                hs_cnt;
    int                ld_cnt;
    int                ur_cnt;
    logic [IX_W-1:0]   pend[$];
    logic [IX_W-1:0]   req_log[$];
    logic [63:0]       recv[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Memory model and observers, all on the falling edge
    always @(negedge clock) begin
        if (rsp_en && pend.size() != 0) begin
            rspValid = 1'b1;
            rspData  = CELL_W'({rsp_serial, 32'(pend.pop_front())});
            rsp_serial++;
        end else begin
            rspValid = 1'b0;
            rspData  = '0;
        end
        if (reqValid && reqReady) begin
            pend.push_back(reqIx);
            req_log.push_back(reqIx);
            hs_cnt++;
        end
        if (cellValid && cellReady) recv.push_back(cellData[63:0]);
        if (lineDone) ld_cnt++;
        if (underrun) ur_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic line_start(input logic [IX_W-1:0] b);
        @(posedge clock); #1;
        lineStart = 1'b1;
        lineBase  = b;
        @(posedge clock); #1;
        lineStart = 1'b0;
    endtask

    task automatic wait_line(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (ld_cnt >= 1) break;
            cyc(1);
        end
        cyc(3);
    endtask

    task automatic clear_obs();
        hs_cnt = 0;
        ld_cnt = 0;
        ur_cnt = 0;
        req_log.delete();
        recv.delete();
    endtask

    initial begin
        reset = 1'b0; lineStart = 1'b0; lineBase = '0; reqReady = 1'b0;
        rspValid = 1'b0; rspData = '0; cellReady = 1'b0; rsp_en = 1'b0;
        rsp_serial = 0; hs_cnt = 0; ld_cnt = 0; ur_cnt = 0;

        cyc(3);
        check("rst_reqValid", 64'(reqValid), 64'd0);
        check("rst_cellValid", 64'(cellValid), 64'd0);
        check("rst_lineDone", 64'(lineDone), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
`ifdef JX2_TXTPF_UNDERRUN_CNT_EN
        check("rst_underrunCnt", 64'(underrunCnt), 64'd0);
`endif
        reset = 1'b1;
        cyc(2);

        // Full line at base 100, response one cycle after each request
        clear_obs();
        rsp_serial = 0;
        cellReady = 1'b1; reqReady = 1'b1; rsp_en = 1'b1;
        line_start(14'd100);
        wait_line(2000);
        check("line_cells", 64'(recv.size()), 64'd80);
        for (int i = 0; i < 80; i++) begin
            if (i < recv.size()) check($sformatf("line_cell%0d", i), recv[i], {32'(i), 32'(100 + i)});
        end
        check("line_done_once", 64'(ld_cnt), 64'd1);
        check("line_idle_noreq", 64'(reqValid), 64'd0);

        // Index wrap-around past 2^IX_W-1
        clear_obs();
        line_start(14'd16380);
        wait_line(2000);
        check("wrap_nreq", 64'(req_log.size() >= 8), 64'd1);
        for (int i = 0; i < 8; i++) begin
            logic [IX_W-1:0] e;
            e = IX_W'(16380 + i);
            if (i < req_log.size()) check($sformatf("wrap_ix%0d", i), 64'(req_log[i]), 64'(e));
        end
        check("wrap_done", 64'(ld_cnt), 64'd1);

        // Consumer stalled: credit limit caps requests at FIFO depth
        clear_obs();
        cellReady = 1'b0;
        line_start(14'd200);
        cyc(40);
        check("bp_nreq", 64'(hs_cnt), 64'd8);
        check("bp_reqValid", 64'(reqValid), 64'd0);
        check("bp_cellValid", 64'(cellValid), 64'd1);
        check("bp_fifo_cnt", 64'(dut.fifo_cnt_q), 64'd8);
        cellReady = 1'b1;
        wait_line(2000);
        check("bp_cells", 64'(recv.size()), 64'd80);
        if (recv.size() == 80) begin
            check("bp_first", 64'(recv[0][31:0]), 64'd200);
            check("bp_last", 64'(recv[79][31:0]), 64'd279);
        end
        check("bp_done", 64'(ld_cnt), 64'd1);

        // Abort with five requests outstanding
        clear_obs();
        rsp_en = 1'b0; rsp_serial = 0; reqReady = 1'b1;
        line_start(14'd300);
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (hs_cnt >= 5) break;
        end
        reqReady = 1'b0;
        check("ab_outstanding", 64'(hs_cnt), 64'd5);
        cyc(2);
        line_start(14'd400);
        recv.delete();
        reqReady = 1'b1; rsp_en = 1'b1;
        wait_line(2000);
        check("ab_cells", 64'(recv.size()), 64'd80);
        if (recv.size() == 80) begin
            check("ab_first", recv[0], {32'd5, 32'd400});
            check("ab_last", 64'(recv[79][31:0]), 64'd479);
        end
        check("ab_done_once", 64'(ld_cnt), 64'd1);
        check("ab_discard_zero", 64'(dut.discard_q), 64'd0);

        // Reset mid-line, stale responses must be ignored
        clear_obs();
        cellReady = 1'b0; reqReady = 1'b1; rsp_en = 1'b0;
        line_start(14'd50);
        cyc(3);
        reqReady = 1'b0;
        check("mr_pending", 64'(pend.size() != 0), 64'd1);
        reset = 1'b0;
        cyc(1);
        check("mr_reqValid", 64'(reqValid), 64'd0);
        reset = 1'b1;
        rsp_en = 1'b1;
        cyc(10);
        check("mr_drained", 64'(pend.size()), 64'd0);
        check("mr_cellValid", 64'(cellValid), 64'd0);
        check("mr_fifo_cnt", 64'(dut.fifo_cnt_q), 64'd0);

        // No underrun while idle
        ur_cnt = 0;
        cellReady = 1'b1;
        cyc(5);
        cellReady = 1'b0;
        cyc(2);
        check("ur_idle", 64'(ur_cnt), 64'd0);

        // Three underrun cycles in FETCH with an empty FIFO
        reqReady = 1'b0;
        line_start(14'd0);
        cyc(2);
        cellReady = 1'b1;
        cyc(3);
        cellReady = 1'b0;
        cyc(3);
        check("ur_fetch", 64'(ur_cnt), 64'd3);
`ifdef JX2_TXTPF_UNDERRUN_CNT_EN
        check("ur_cnt3", 64'(underrunCnt), 64'd3);
        cellReady = 1'b1;
        cyc(65540);
        cellReady = 1'b0;
        cyc(2);
        check("ur_cnt_sat", 64'(underrunCnt), 64'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
